// File: rtl/f1_start_ctrl.sv
// rtl/f1_start_ctrl.sv - race-start controller: paces the light FSM, holds a random delay, times the reaction
module f1_start_ctrl #(
    parameter int D_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 tick,
    input  logic                 react,
    input  logic [D_WIDTH-1:0]   fsm_lights,
    output logic                 fsm_en,
    output logic                 fsm_clr,
    output logic [D_WIDTH-1:0]   lights_out,
    output logic                 busy,
    output logic                 time_valid,
    output logic [CNT_WIDTH-1:0] reaction_time,
    output logic                 jump_start
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        HOLD = 2'd2,
        GO   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [6:0]           lfsr;
    logic [6:0]           delay_cnt;
    logic [CNT_WIDTH-1:0] rt_cnt;

    logic all_lit;
    logic start;
    logic load_delay;
    logic dec_delay;
    logic go_enter;
    logic capture;
    logic jump;

    assign all_lit = &fsm_lights;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // react is tested first in SEQ and HOLD so it wins over all-lit and the final tick
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        load_delay = 1'b0;
        dec_delay  = 1'b0;
        go_enter   = 1'b0;
        capture    = 1'b0;
        jump       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = SEQ;
                    start     = 1'b1;
                end
            end
            SEQ: begin
                if (react) begin
                    state_nxt = IDLE;
                    jump      = 1'b1;
                end else if (all_lit) begin
                    state_nxt  = HOLD;
                    load_delay = 1'b1;
                end
            end
            HOLD: begin
                if (react) begin
                    state_nxt = IDLE;
                    jump      = 1'b1;
                end else if (tick) begin
                    if (delay_cnt == 7'd1) begin
                        state_nxt = GO;
                        go_enter  = 1'b1;
                    end else begin
                        dec_delay = 1'b1;
                    end
                end
            end
            GO: begin
                if (react) begin
                    state_nxt = IDLE;
                    capture   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign fsm_en     = tick && (state == SEQ) && !fsm_clr;
    assign lights_out = ((state == SEQ) || (state == HOLD)) ? fsm_lights : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr          <= 7'h01;
            delay_cnt     <= 7'd0;
            rt_cnt        <= '0;
            fsm_clr       <= 1'b0;
            time_valid    <= 1'b0;
            reaction_time <= '0;
            jump_start    <= 1'b0;
        end else begin
            lfsr       <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            fsm_clr    <= start;
            time_valid <= capture || jump;

            if (load_delay) begin
                delay_cnt <= lfsr;
            end else if (dec_delay) begin
                delay_cnt <= delay_cnt - 7'd1;
            end

            // timer saturates so a very late press reads as the maximum, never a small wrapped value
            if (go_enter) begin
                rt_cnt <= '0;
            end else if ((state == GO) && (rt_cnt != '1)) begin
                rt_cnt <= rt_cnt + CNT_WIDTH'(1);
            end

            if (jump) begin
                reaction_time <= '0;
            end else if (capture) begin
                reaction_time <= rt_cnt;
            end

            if (start) begin
                jump_start <= 1'b0;
            end else if (jump) begin
                jump_start <= 1'b1;
            end
        end
    end

endmodule
